// File: rtl/dac_tlc5615_drv.sv
// Serial driver for a TLC5615-class 10-bit DAC with a one-deep sample holding buffer.
// Optional build macro DAC_SIGNED_IN_EN: treat in_data as two's complement (converted to offset binary).
module dac_tlc5615_drv #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8,
  parameter int unsigned DATA_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              overrun_clr,
  output logic              overrun,
  output logic              busy,
  output logic              frame_done,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_din
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e              r_state;
  logic [DATA_W-1:0]   r_buf;
  logic                r_buf_full;
  logic                r_overrun;
  logic [FRAME_W-1:0]  r_shift;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic                r_cs_n;
  logic                r_sclk;
  logic                r_busy;
  logic                r_frame_done;

  logic                w_take;
  logic [DATA_W-1:0]   w_conv;

  assign w_take = (r_state == StIdle) && r_buf_full;

`ifdef DAC_SIGNED_IN_EN
  assign w_conv = {~r_buf[DATA_W-1], r_buf[DATA_W-2:0]};
`else
  assign w_conv = r_buf;
`endif

  // A strobe on the take cycle refills the buffer without counting as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (in_valid) begin
        r_buf      <= in_data;
        r_buf_full <= 1'b1;
      end else if (w_take) begin
        r_buf_full <= 1'b0;
      end
      if (in_valid && r_buf_full && !w_take) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_div        <= '0;
      r_bit        <= '0;
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_buf_full) begin
            r_shift <= {w_conv, 2'b00};
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= DIV_W'(CLK_DIV - 1);
            r_bit   <= BIT_W'(FRAME_W - 1);
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_div   <= DIV_W'(CLK_DIV - 1);
            r_sclk  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          // r_bit counts the high phases still to come; the frame ends after the low
          // phase that follows the last one.
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else if (r_sclk) begin
            r_div   <= DIV_W'(CLK_DIV - 1);
            r_sclk  <= 1'b0;
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
          end else if (r_bit == '0) begin
            r_div        <= DIV_W'(CS_GAP - 1);
            r_cs_n       <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= StHold;
          end else begin
            r_div  <= DIV_W'(CLK_DIV - 1);
            r_bit  <= r_bit - 1'b1;
            r_sclk <= 1'b1;
          end
        end
        StHold: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready   = ~r_buf_full;
  assign overrun    = r_overrun;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign dac_cs_n   = r_cs_n;
  assign dac_sclk   = r_sclk;
  assign dac_din    = r_shift[FRAME_W-1];

endmodule

// File: tb/tb_dac_tlc5615_drv.sv
// Bench for dac_tlc5615_drv: directed vector table, corner sequences and a random run
// checked against a cycle-count reference model and a pin-level frame decoder.
module tb_dac_tlc5615_drv;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned CS_GAP    = 8;
  localparam int unsigned DATA_W    = 10;
  localparam int          FRAME_CYC = 25 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       in_ready, overrun, busy, frame_done, dac_cs_n, dac_sclk, dac_din;

  dac_tlc5615_drv #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP),
    .DATA_W  (DATA_W)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .overrun_clr (overrun_clr),
    .overrun     (overrun),
    .busy        (busy),
    .frame_done  (frame_done),
    .dac_cs_n    (dac_cs_n),
    .dac_sclk    (dac_sclk),
    .dac_din     (dac_din)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected 12-bit frame for a sample, from the arithmetic meaning of the data.
  function automatic logic [11:0] frame_of(input logic [9:0] d);
    int v;
    v = int'(d);
`ifdef DAC_SIGNED_IN_EN
    v = (v + 512) % 1024;
`endif
    return 12'(v * 4);
  endfunction

  typedef struct {
    logic [11:0] word;
    int          fall;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] cap_q[$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a buffered sample is taken once the FSM has become free again.
  logic       m_full = 1'b0;
  logic [9:0] m_buf = '0;
  logic       m_over = 1'b0;
  logic       m_busy = 1'b0;
  int         m_next = 0;
  int         m_busy_until = 0;

  initial begin
    int   c;
    logic take, set_ov;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_full = 1'b0; m_buf = '0; m_over = 1'b0; m_busy = 1'b0;
        m_next = 0; m_busy_until = 0;
        exp_q.delete();
      end else begin
        c = cyc;
        take = m_full && (c >= m_next);
        if (take) begin
          exp_q.push_back('{word: frame_of(m_buf), fall: c + 1});
          m_busy_until = c + FRAME_CYC + CS_GAP;
          m_next = c + FRAME_CYC + CS_GAP + 1;
        end
        set_ov = in_valid && m_full && !take;
        if (in_valid) begin
          m_buf = in_data; m_full = 1'b1;
        end else if (take) begin
          m_full = 1'b0;
        end
        if (set_ov) m_over = 1'b1;
        else if (overrun_clr) m_over = 1'b0;
        m_busy = (c < m_busy_until);
      end
    end
  end

  // Pin-level monitor, sampled on the falling clock edge.
  logic        mon_prev_cs = 1'b1;
  logic        mon_prev_sclk = 1'b0;
  logic        mon_in_frame = 1'b0;
  int          mon_len = 0;
  int          mon_nr = 0;
  int          mon_hi = CS_GAP;
  logic [11:0] mon_word = '0;
  logic        mon_rise_din = 1'b0;
  exp_t        mon_cur;

  initial forever begin
    @(negedge reset_n);
    mon_prev_cs = 1'b1; mon_prev_sclk = 1'b0; mon_in_frame = 1'b0; mon_hi = CS_GAP;
  end

  initial forever begin
    logic rise_cs, fall_cs;
    @(negedge clk);
    rise_cs = !mon_prev_cs && dac_cs_n;
    fall_cs = mon_prev_cs && !dac_cs_n;
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("in_ready", 32'(in_ready), 32'(!m_full));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(rise_cs && mon_in_frame));
    if (dac_cs_n) chk("sclk_idle", 32'(dac_sclk), 32'(0));
    if (fall_cs) begin
      chk("cs_gap", 32'(mon_hi >= int'(CS_GAP)), 32'(1));
      chk("frame_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        mon_cur = exp_q.pop_front();
        chk("cs_fall_cycle", 32'(cyc), 32'(mon_cur.fall));
        mon_in_frame = 1'b1; mon_len = 0; mon_nr = 0; mon_word = '0;
      end
    end
    if (mon_in_frame && !dac_cs_n) begin
      mon_len++;
      if (dac_sclk && !mon_prev_sclk) begin
        mon_word = {mon_word[10:0], dac_din};
        mon_nr++;
        mon_rise_din = dac_din;
      end else if (dac_sclk && mon_prev_sclk) begin
        chk("din_stable", 32'(dac_din), 32'(mon_rise_din));
      end
    end
    if (rise_cs && mon_in_frame) begin
      chk("frame_word", 32'(mon_word), 32'(mon_cur.word));
      chk("sclk_rises", 32'(mon_nr), 32'(12));
      chk("frame_len", 32'(mon_len), 32'(FRAME_CYC));
      cap_q.push_back(mon_word);
      mon_in_frame = 1'b0;
      mon_hi = 0;
    end
    if (dac_cs_n) mon_hi++;
    mon_prev_cs = dac_cs_n;
    mon_prev_sclk = dac_sclk;
  end

  task automatic strobe(input logic [9:0] d, input logic clr);
    @(negedge clk);
    in_data = d; in_valid = 1'b1; overrun_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_word(input string name, input logic [11:0] exp);
    chk({name, "_present"}, 32'(cap_q.size() > 0), 32'(1));
    if (cap_q.size() > 0) chk(name, 32'(cap_q.pop_front()), 32'(exp));
  endtask

  typedef struct {
    logic [9:0]  data;
    int          gap;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [11:0] flip;

  initial begin
`ifdef DAC_SIGNED_IN_EN
    flip = 12'h800;
`else
    flip = 12'h000;
`endif
    vecs[0] = '{data: 10'h2A5, gap: 500, exp: 12'hA94};
    vecs[1] = '{data: 10'h001, gap: 500, exp: 12'h004};
    vecs[2] = '{data: 10'h3FF, gap: 500, exp: 12'hFFC};
    vecs[3] = '{data: 10'h200, gap: 500, exp: 12'h800};
    vecs[4] = '{data: 10'h000, gap: 500, exp: 12'h000};
    vecs[5] = '{data: 10'h3C3, gap: 500, exp: 12'hF0C};

    #1 reset_n = 1'b0;
    idle(3);
    chk("rst_cs_n", 32'(dac_cs_n), 32'(1));
    chk("rst_sclk", 32'(dac_sclk), 32'(0));
    chk("rst_din", 32'(dac_din), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    reset_n = 1'b1;
    idle(2);

    // Directed vectors, one frame each.
    cap_q.delete();
    for (int i = 0; i < 6; i++) begin
      strobe(vecs[i].data, 1'b0);
      idle(vecs[i].gap);
      chk($sformatf("vec%0d_count", i), 32'(cap_q.size()), 32'(1));
      chk_word($sformatf("vec%0d_word", i), vecs[i].exp ^ flip);
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(0));
    end

    // Overrun: latest sample wins, clear, then set beats clear.
    cap_q.delete();
    strobe(10'h100, 1'b0); idle(19);
    strobe(10'h155, 1'b0); idle(19);
    strobe(10'h0AA, 1'b0); idle(2);
    chk("ovr_set", 32'(overrun), 32'(1));
    idle(300);
    chk("ovr_frames", 32'(cap_q.size()), 32'(2));
    chk_word("ovr_word1", 12'h400 ^ flip);
    chk_word("ovr_word2", 12'h2A8 ^ flip);
    pulse_clr();
    chk("ovr_cleared", 32'(overrun), 32'(0));
    strobe(10'h111, 1'b0); idle(9);
    strobe(10'h222, 1'b0); idle(9);
    strobe(10'h333, 1'b1);
    chk("ovr_set_wins", 32'(overrun), 32'(1));
    idle(300);
    chk("ovr2_frames", 32'(cap_q.size()), 32'(2));
    chk_word("ovr2_word1", 12'h444 ^ flip);
    chk_word("ovr2_word2", 12'hCCC ^ flip);
    pulse_clr();

    // Strobe landing on the exact cycle the FSM takes the buffer.
    begin
      int got;
      cap_q.delete();
      strobe(10'h0F0, 1'b0); idle(4);
      strobe(10'h10F, 1'b0);
      got = 0;
      for (int i = 0; i < 300 && got == 0; i++) begin
        @(negedge clk);
        if (frame_done) got = 1;
      end
      chk("coinc_frame_done_seen", 32'(got), 32'(1));
      idle(CS_GAP - 1);
      strobe(10'h1E1, 1'b0);
      chk("coinc_no_overrun", 32'(overrun), 32'(0));
      chk("coinc_buf_full", 32'(in_ready), 32'(0));
      chk("coinc_busy", 32'(busy), 32'(1));
      idle(300);
      chk("coinc_frames", 32'(cap_q.size()), 32'(3));
      chk_word("coinc_word1", 12'h3C0 ^ flip);
      chk_word("coinc_word2", 12'h43C ^ flip);
      chk_word("coinc_word3", 12'h784 ^ flip);
    end

    // Asynchronous reset in the middle of the shift phase.
    begin
      int   n;
      logic prev;
      cap_q.delete();
      strobe(10'h155, 1'b0);
      n = 0; prev = 1'b0;
      for (int i = 0; i < 300 && n < 6; i++) begin
        @(negedge clk);
        if (dac_sclk && !prev) n++;
        prev = dac_sclk;
      end
      chk("mid_rises_seen", 32'(n), 32'(6));
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_cs_n", 32'(dac_cs_n), 32'(1));
      chk("mid_rst_sclk", 32'(dac_sclk), 32'(0));
      chk("mid_rst_din", 32'(dac_din), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
      idle(3);
      reset_n = 1'b1;
      idle(2);
      strobe(10'h3C3, 1'b0);
      idle(300);
      chk("post_rst_frames", 32'(cap_q.size()), 32'(1));
      chk_word("post_rst_word", 12'hF0C ^ flip);
    end

    // Random strobes and clears against the reference model.
    pulse_clr();
    repeat (60) begin
      strobe(10'($urandom), ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 240));
    end
    idle(300);
    chk("rand_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_tlc5615_drv.md
Name: dac_tlc5615_drv

Overview:
- Downstream stage of the FIR filter. Takes each filtered 10-bit sample and drives it serially into a TLC5615-class 10-bit serial DAC.
- A one-deep holding buffer decouples the FIR sample strobe (100 kHz) from the serial frame timing.
- Uses the same 50 MHz system clock as the FIR. Each frame is 12 bits, MSB first: 10 data bits followed by 2 zero bits.
- Chip select rising at the end of a frame loads the DAC.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (min 1).
- CS_GAP, 8, system clocks cs_n held high between frames (min 1).
- DATA_W, 10, sample width; frame = DATA_W+2 bits.

Ports:
- clk  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous active-low reset
- in_data  input  10  sample from FIR (unsigned offset binary)
- in_valid  input  1  one-cycle strobe, in_data valid
- in_ready  output  1  holding buffer empty
- overrun_clr  input  1  clears overrun flag
- overrun  output  1  sticky: a buffered sample was overwritten
- busy  output  1  FSM not in IDLE
- frame_done  output  1  one-cycle pulse on the cycle cs_n returns high
- dac_cs_n  output  1  DAC chip select, active low
- dac_sclk  output  1  DAC serial clock
- dac_din  output  1  DAC serial data

Behaviour:
- Reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, overrun=0, in_ready=1, buffer empty, FSM=IDLE.
- Reset is asynchronous and active-low, and applies mid-frame. Forcing cs_n high makes the DAC latch a partial word; this is accepted, and the next frame after reset corrects the output.
- Holding buffer:
  - in_valid loads in_data into the buffer at that clock edge and sets it full.
  - If the buffer is already full, the new sample overwrites it and overrun is set (latest sample wins).
  - If in_valid coincides with the FSM taking the buffer, the new sample is loaded, the buffer stays full, and overrun is not set.
- overrun clears on overrun_clr. Set wins if both occur in the same cycle.
- All outputs are registered; no combinational path from inputs to DAC pins.
- FSM states:
  - IDLE: when the buffer is full, load the shift register with {buffer,2'b00}, mark the buffer empty, drive cs_n=0 and din=MSB, go to SETUP.
  - SETUP: hold for CLK_DIV cycles with sclk=0 (satisfies CS-to-SCLK setup), then go to SHIFT.
  - SHIFT: each bit is sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles. On each falling sclk edge, din advances to the next bit. After the 12th high phase, sclk returns to 0, the following low phase completes, then go to HOLD.
  - HOLD: cs_n=1 and frame_done pulses on entry. Hold for CS_GAP cycles, then go to IDLE.
- Timing:
  - The DAC samples din on the sclk rising edge. din is stable for CLK_DIV cycles either side of that edge.
  - Latency: in_valid at edge k with the FSM in IDLE gives the cs_n fall at edge k+1.
  - Frame length, cs_n fall to cs_n rise, is CLK_DIV*(1+24) cycles; with defaults this is 100 cycles.
  - Cycles between consecutive cs_n falls = 101 + CS_GAP = 109 with defaults, well under the 500-clock sample period.
- Bit counter: 4 bits, counts 11 down to 0 and does not wrap. The frame ends at 0.
- busy=1 in SETUP, SHIFT and HOLD.

Optional Feature:
- Macro DAC_SIGNED_IN_EN.
- Defined: in_data is two's complement and is converted to offset binary by inverting bit DATA_W-1 when loaded into the shift register. Examples: 10'h200 → 10'h000; 10'h1FF → 10'h3FF.
- Undefined: in_data passes through unchanged.
- The buffer and overrun logic are identical in both builds.

Test Plan:
- Single sample: in_data=10'h2A5, one strobe → cs_n falls 1 cycle later; 12 sclk rises; din sampled at the rises reads 1010100101_00; cs_n high after 100 cycles; frame_done pulses once.
- Back-to-back: strobes of 10'h001 then 10'h3FF with a 500-cycle gap → two frames; words 0000000001_00 and 1111111111_00; cs_n high for ≥ CS_GAP cycles between frames; overrun=0.
- Overrun: strobes of 10'h100, 10'h155, 10'h0AA at 20-cycle spacing → frame 1 sends 10'h100; overrun=1; frame 2 sends 10'h0AA; overrun_clr pulse → 0; overrun_clr coinciding with a new overrun leaves overrun=1.
- Coincident take/load: strobe timed on the exact IDLE-exit cycle → no overrun; that sample is sent in the next frame.
- Reset mid-SHIFT at bit 5 → immediately cs_n=1, sclk=0, din=0, busy=0, in_ready=1; the next strobe of 10'h3C3 produces a clean full frame.
- With DAC_SIGNED_IN_EN defined: in_data=10'h200 → frame bits all zero; in_data=10'h000 → 1000000000_00.
